// File: rtl/spi_fault_ctrl.sv
// spi_fault_ctrl: folds synchronized SPI status flags into sticky fault bits,
// captures the first fault, sequences an SPI shutdown and streams every
// latched fault bit exactly once as a {category, channel} record.
module spi_fault_ctrl #(
    parameter int N_CAT = 12,
    parameter int N_CH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_CAT*N_CH-1:0] sts_in,
    input  logic                  spi_off,
    input  logic                  clear,
    output logic                  fault,
    output logic [3:0]            first_cat,
    output logic [2:0]            first_ch,
    output logic                  shutdown_req,
    output logic                  halted,
    output logic [15:0]           rec_data,
    output logic                  rec_valid,
    input  logic                  rec_ready
);

    typedef logic [N_CAT-1:0][N_CH-1:0] vec_t;
    typedef enum logic [1:0] {ST_RUN, ST_SHUTDOWN, ST_HALTED} state_t;

    state_t      r_state;
    vec_t        r_sticky;
    vec_t        r_reported;
    logic        r_fault;
    logic [3:0]  r_first_cat;
    logic [2:0]  r_first_ch;
    logic        r_clr_pend;
    logic        r_shutdown_req;
    logic        r_halted;
    logic [3:0]  r_cat_ptr;
    logic [15:0] r_rec_data;
    logic        r_rec_valid;

    vec_t            w_sts;
    vec_t            w_sticky_base;
    vec_t            w_new;
    vec_t            w_pend;
    logic [N_CH-1:0] w_pend_cat;
    logic            w_can_load;
    logic            w_apply;
    logic            w_fault_rise;
    logic            w_load;
    logic [2:0]      w_ld_ch;
    logic [6:0]      w_first;

    // Lowest set flat index, returned as {category, channel}.
    function automatic logic [6:0] lowest_flat(input vec_t v);
        logic [6:0] r;
        r = '0;
        for (int c = N_CAT - 1; c >= 0; c--) begin
            for (int h = N_CH - 1; h >= 0; h--) begin
                if (v[c][h]) r = {4'(c), 3'(h)};
            end
        end
        return r;
    endfunction

    // Lowest set channel within one category.
    function automatic logic [2:0] lowest_ch(input logic [N_CH-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int h = N_CH - 1; h >= 0; h--) begin
            if (v[h]) r = 3'(h);
        end
        return r;
    endfunction

    // A clear is held off while shutting down or while a record is stalled,
    // so a record is never withdrawn before the consumer accepts it.
    always_comb begin
        w_sts         = sts_in;
        w_can_load    = !r_rec_valid || rec_ready;
        w_apply       = r_clr_pend && (r_state != ST_SHUTDOWN) && w_can_load;
        w_sticky_base = w_apply ? '0 : r_sticky;
        w_new         = w_sts & ~w_sticky_base;
        w_fault_rise  = !(r_fault && !w_apply) && (|w_new);
        w_first       = lowest_flat(w_new);
        w_pend        = r_sticky & ~r_reported;
        w_pend_cat    = w_pend[r_cat_ptr];
        w_ld_ch       = lowest_ch(w_pend_cat);
        w_load        = w_can_load && !w_apply && (|w_pend_cat);
    end

    // Sticky accumulation, first-fault capture and clear bookkeeping.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sticky    <= '0;
            r_fault     <= 1'b0;
            r_first_cat <= '0;
            r_first_ch  <= '0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_sticky   <= w_sticky_base | w_sts;
            r_clr_pend <= clear || (r_clr_pend && !w_apply);
            if (w_apply) begin
                r_fault     <= 1'b0;
                r_first_cat <= '0;
                r_first_ch  <= '0;
            end
            // A fault arriving in the clear cycle wins over the clear.
            if (w_fault_rise) begin
                r_fault     <= 1'b1;
                r_first_cat <= w_first[6:3];
                r_first_ch  <= w_first[2:0];
            end
        end
    end

    // Shutdown sequencer with registered request/halted outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state        <= ST_RUN;
            r_shutdown_req <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fault_rise) begin
                        r_state        <= ST_SHUTDOWN;
                        r_shutdown_req <= 1'b1;
                    end
                end
                ST_SHUTDOWN: begin
                    if (spi_off) begin
                        r_state        <= ST_HALTED;
                        r_shutdown_req <= 1'b0;
                        r_halted       <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // A fresh fault in the clear cycle restarts the shutdown.
                    if (w_apply) begin
                        r_halted <= 1'b0;
                        if (w_fault_rise) begin
                            r_state        <= ST_SHUTDOWN;
                            r_shutdown_req <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state        <= ST_RUN;
                    r_shutdown_req <= 1'b0;
                    r_halted       <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin record scanner; the pointer dwells on a category until empty.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_reported  <= '0;
            r_cat_ptr   <= '0;
            r_rec_data  <= '0;
            r_rec_valid <= 1'b0;
        end else begin
            if (w_apply) begin
                r_reported <= '0;
            end else if (w_load) begin
                r_reported[r_cat_ptr][w_ld_ch] <= 1'b1;
            end
            if (w_load) begin
                r_rec_valid <= 1'b1;
                r_rec_data  <= {4'b0, r_cat_ptr, 5'b0, w_ld_ch};
            end else if (rec_ready) begin
                r_rec_valid <= 1'b0;
            end
            if (!w_load) begin
                if (r_cat_ptr == 4'(N_CAT - 1)) r_cat_ptr <= '0;
                else                            r_cat_ptr <= r_cat_ptr + 4'd1;
            end
        end
    end

    assign fault        = r_fault;
    assign first_cat    = r_first_cat;
    assign first_ch     = r_first_ch;
    assign shutdown_req = r_shutdown_req;
    assign halted       = r_halted;
    assign rec_data     = r_rec_data;
    assign rec_valid    = r_rec_valid;

endmodule

// File: tb/tb_spi_fault_ctrl.sv
// Scoreboard bench for spi_fault_ctrl: stimulus pushes expected records,
// an independent monitor pops them on every accepted transfer.
module tb_spi_fault_ctrl;

    localparam int N_CAT = 12;
    localparam int N_CH  = 8;
    localparam int NB    = N_CAT * N_CH;

    logic          aclk;
    logic          aresetn;
    logic [NB-1:0] sts_in;
    logic          spi_off;
    logic          clear;
    logic          fault;
    logic [3:0]    first_cat;
    logic [2:0]    first_ch;
    logic          shutdown_req;
    logic          halted;
    logic [15:0]   rec_data;
    logic          rec_valid;
    logic          rec_ready;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    spi_fault_ctrl #(.N_CAT(N_CAT), .N_CH(N_CH)) dut (
        .aclk(aclk), .aresetn(aresetn), .sts_in(sts_in), .spi_off(spi_off),
        .clear(clear), .fault(fault), .first_cat(first_cat), .first_ch(first_ch),
        .shutdown_req(shutdown_req), .halted(halted), .rec_data(rec_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            tick(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name, input int maxc);
        int k = 0;
        while (!rec_valid && k < maxc) begin
            tick(1);
            k++;
        end
        chk(name, rec_valid, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_first_cat"}, first_cat, 0);
        chk({tag, "_first_ch"}, first_ch, 0);
        chk({tag, "_shutdown_req"}, shutdown_req, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_rec_valid"}, rec_valid, 0);
        chk({tag, "_rec_data"}, rec_data, 0);
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", rec_data, 16'hFFFF);
            end else begin
                chk("record", rec_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] cap;
        logic        stable;
        aresetn = 1'b0; sts_in = '0; spi_off = 1'b0; clear = 1'b0; rec_ready = 1'b1;

        // Reset and idle
        tick(3);
        check_idle_outputs("reset");
        aresetn = 1'b1;
        tick(20);
        chk("idle_rec_valid", rec_valid, 0);
        chk("idle_fault", fault, 0);

        // Single fault cat3/ch5
        exp_q.push_back(16'h0305);
        sts_in[3*8+5] = 1'b1;
        tick(1);
        sts_in = '0;
        chk("single_fault", fault, 1);
        chk("single_first_cat", first_cat, 3);
        chk("single_first_ch", first_ch, 5);
        chk("single_shutdown_req", shutdown_req, 1);
        wait_drain("single_record_latency", 14);
        tick(14);
        spi_off = 1'b1;
        tick(1);
        spi_off = 1'b0;
        chk("single_halted", halted, 1);
        chk("single_shutdown_off", shutdown_req, 0);

        // Clear with a new fault (cat1/ch0) in the apply cycle
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        exp_q.push_back(16'h0100);
        sts_in[1*8+0] = 1'b1;
        tick(1);
        sts_in = '0;
        chk("clrnew_fault", fault, 1);
        chk("clrnew_first_cat", first_cat, 1);
        chk("clrnew_first_ch", first_ch, 0);
        wait_drain("clrnew_record", 16);
        tick(14);
        spi_off = 1'b1;
        tick(1);
        spi_off = 1'b0;
        chk("clrnew_halted", halted, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        chk("plainclr_fault", fault, 0);
        chk("plainclr_first_cat", first_cat, 0);
        chk("plainclr_first_ch", first_ch, 0);
        chk("plainclr_halted", halted, 0);
        chk("plainclr_shutdown_req", shutdown_req, 0);

        // Simultaneous faults after a fresh reset so the scan order is known
        aresetn = 1'b0;
        tick(1);
        check_idle_outputs("reset2");
        aresetn = 1'b1;
        tick(10);
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0201);
        exp_q.push_back(16'h0204);
        sts_in[0*8+7] = 1'b1;
        sts_in[2*8+1] = 1'b1;
        sts_in[2*8+4] = 1'b1;
        tick(1);
        sts_in = '0;
        chk("multi_fault", fault, 1);
        chk("multi_first_cat", first_cat, 0);
        chk("multi_first_ch", first_ch, 7);
        wait_drain("multi_records", 20);
        tick(14);

        // Clear requested during SHUTDOWN is deferred until HALTED
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(4);
        chk("clrshut_fault_held", fault, 1);
        chk("clrshut_shutdown_req", shutdown_req, 1);
        chk("clrshut_first_ch", first_ch, 7);
        spi_off = 1'b1;
        tick(1);
        spi_off = 1'b0;
        chk("clrshut_halted", halted, 1);
        tick(1);
        chk("clrshut_fault_cleared", fault, 0);
        chk("clrshut_run_halted", halted, 0);
        chk("clrshut_run_shutdown", shutdown_req, 0);

        // Backpressure: record must hold steady while ready is low
        rec_ready = 1'b0;
        exp_q.push_back(16'h0502);
        sts_in[5*8+2] = 1'b1;
        sts_in[5*8+6] = 1'b1;
        tick(1);
        sts_in = '0;
        wait_valid("bp_valid", 20);
        cap = rec_data;
        chk("bp_first_record", cap, 16'h0502);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!rec_valid || rec_data !== cap) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        spi_off = 1'b1;
        tick(1);
        spi_off = 1'b0;
        chk("bp_halted", halted, 1);

        // Clear while stalled applies on the handshake; ch6 is dropped
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(3);
        chk("clrstall_deferred", fault, 1);
        chk("clrstall_valid_held", rec_valid, 1);
        rec_ready = 1'b1;
        tick(1);
        chk("clrstall_fault", fault, 0);
        chk("clrstall_halted", halted, 0);
        chk("clrstall_drained", exp_q.size(), 0);
        tick(15);
        chk("clrstall_no_more", rec_valid, 0);

        // Reset mid-transfer drops the record immediately
        rec_ready = 1'b0;
        sts_in[0] = 1'b1;
        tick(1);
        sts_in = '0;
        wait_valid("rstmid_valid", 20);
        aresetn = 1'b0;
        tick(1);
        chk("rstmid_rec_valid", rec_valid, 0);
        chk("rstmid_fault", fault, 0);
        aresetn = 1'b1;
        rec_ready = 1'b1;
        tick(15);
        chk("rstmid_no_record", rec_valid, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_fault_ctrl.md
Name: spi_fault_ctrl

Overview:
- Sits in the AXI clock domain, directly downstream of the SPI status synchronizer.
- Folds the stable per-channel status vectors into sticky fault bits and records the first fault (category and channel).
- Sequences an orderly SPI shutdown on the first fault.
- Serialises every latched fault bit, exactly once, as a record on a valid/ready stream for the status FIFO / CPU.

Parameters:
- N_CAT, 12: number of status categories (over_thresh … unexp_adc_trig, fixed index order); max 16.
- N_CH, 8: channels per category; power of two, max 8.

Ports:
- aclk  in  1  AXI clock; one clock.
- aresetn  in  1  reset, synchronous, active-low.
- sts_in  in  N_CAT*N_CH  stable status flags; category c, channel h at bit c*N_CH+h.
- spi_off  in  1  stable SPI-off status.
- clear  in  1  single-cycle request to clear sticky/fault state.
- fault  out  1  sticky "any fault latched".
- first_cat  out  4  category of first fault.
- first_ch  out  3  channel of first fault.
- shutdown_req  out  1  request to SPI system to stop.
- halted  out  1  shutdown complete.
- rec_data  out  16  record: [11:8] category, [2:0] channel, all other bits 0.
- rec_valid  out  1  record valid.
- rec_ready  in  1  consumer ready.

Behaviour:
- Reset (aresetn=0 at posedge) zeroes every output, the sticky, reported and clear-pending state, and the scan pointer. Controller state goes to RUN.
- Sticky: every cycle, sticky <= sticky | sts_in. New bits = sts_in & ~sticky.
- First fault:
  - When fault=0 and any new bit is present, fault <= 1 on the next edge.
  - first_cat/first_ch take the lowest flat bit index among the new bits.
  - Later faults never change first_cat/first_ch until cleared.
- Controller FSM:
  - RUN: shutdown_req=0, halted=0. fault rising moves to SHUTDOWN on the same edge that sets fault, so shutdown_req=1 one cycle after the triggering sts_in.
  - SHUTDOWN: shutdown_req=1. On spi_off=1, move to HALTED (shutdown_req=0, halted=1 next cycle).
  - HALTED: hold until a clear is applied, then move to RUN.
  - spi_off=1 while in RUN is ignored; the FSM stays in RUN.
- Clear:
  - A clear pulse sets clear_pending.
  - It is applied on the first cycle where state≠SHUTDOWN AND (rec_valid=0 OR rec_valid&rec_ready).
  - Applying it zeroes sticky, reported, fault, first_cat and first_ch, and clears clear_pending.
  - A sts_in bit high in the apply cycle is re-latched as sticky (set wins) and counts as a new first fault.
- Record scanner:
  - pending = sticky & ~reported. The scan pointer cat_ptr wraps N_CAT-1 -> 0.
  - When rec_valid=0 (or the handshake completes this cycle) and pending in cat_ptr is nonzero: load the record for the lowest pending channel, set rec_valid, and set that reported bit on the same edge. cat_ptr stays put until the category is empty.
  - Otherwise cat_ptr increments.
  - Worst-case load latency from a sticky bit set to rec_valid is N_CAT+1 cycles. With ready held high, 1 record per cycle within a category.
- Handshake: while rec_valid=1 and rec_ready=0, rec_data and rec_valid hold stable. Transfer happens on rec_valid & rec_ready.
- No bit is reported twice between clears. Bits set and cleared before being reported are dropped.
- Reset mid-transfer drops rec_valid immediately, without waiting for ready.

Test Plan:
- Reset with sts_in=0, clear=0 -> all outputs 0; state RUN; no record for 20 cycles.
- Single fault: sts_in bit 3*8+5 for 1 cycle, rec_ready=1 ->
  - fault=1, first_cat=3, first_ch=5 next cycle; shutdown_req=1 next cycle.
  - exactly one record 0x0305 within 13 cycles.
  - spi_off=1 -> halted=1, shutdown_req=0.
- Simultaneous faults: bits cat0/ch7, cat2/ch1, cat2/ch4 in the same cycle ->
  - first_cat=0, first_ch=7.
  - records 0x0007, 0x0201, 0x0204 in that order, each once.
- Backpressure: rec_ready=0 for 10 cycles with a record pending -> rec_data/rec_valid stable; after ready, no loss or duplication.
- Clear deferral:
  - clear in SHUTDOWN -> no effect until HALTED, then all sticky/fault cleared and state RUN.
  - clear with rec_valid=1 & rec_ready=0 -> applied on the handshake cycle.
- Clear vs. new fault: sts_in bit cat1/ch0 high in the clear-apply cycle -> fault=1, first_cat=1, first_ch=0, record 0x0100 emitted.
